// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       ext_zero;
    logic       retire;
    logic       trap;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, ext_zero, retire, trap, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, ext_zero, retire, trap, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with a memory-wait watchdog that traps
// when mem_ready does not arrive within TIMEOUT cycles.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        StRst     = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAddr = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StExec    = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9,
        StJump    = 4'd10,
        StImmExec = 4'd11,
        StImmWb   = 4'd12,
        StTrap    = 4'd13
    } state_e;

    localparam logic [5:0] op_rtype = 6'h00;
    localparam logic [5:0] op_j     = 6'h02;
    localparam logic [5:0] op_beq   = 6'h04;
    localparam logic [5:0] op_addi  = 6'h08;
    localparam logic [5:0] op_andi  = 6'h0C;
    localparam logic [5:0] op_ori   = 6'h0D;
    localparam logic [5:0] op_lw    = 6'h23;
    localparam logic [5:0] op_sw    = 6'h2B;
    localparam logic [7:0] wait_last = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q;
    logic       wait_inc;
    logic       timeout;
    logic       pc_write, branch;
    logic       ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg;
    logic       alu_src_a, ext_zero, retire, trap;
    logic [1:0] alu_src_b, alu_op, pc_src;

    assign timeout = (wait_cnt_q == wait_last);

    // Next-state and output decode; everything defaults to 0 / hold.
    always_comb begin
        state_d    = state_q;
        wait_inc   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        ext_zero   = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;
        unique case (state_q)
            StRst: state_d = StFetch;
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else begin
                    wait_inc = 1'b1;
                    if (timeout) state_d = StTrap;
                end
            end
            StDecode: begin
                alu_src_b = 2'b11;
                case (bus.opcode)
                    op_rtype:                 state_d = StExec;
                    op_lw, op_sw:             state_d = StMemAddr;
                    op_beq:                   state_d = StBranch;
                    op_j:                     state_d = StJump;
                    op_addi, op_andi, op_ori: state_d = StImmExec;
                    default:                  state_d = StTrap;
                endcase
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.opcode == op_lw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (bus.mem_ready) begin
                    state_d = StMemWb;
                end else begin
                    wait_inc = 1'b1;
                    if (timeout) state_d = StTrap;
                end
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end else begin
                    wait_inc = 1'b1;
                    if (timeout) state_d = StTrap;
                end
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StJump: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StImmExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                ext_zero  = (bus.opcode == op_andi) || (bus.opcode == op_ori);
                state_d   = StImmWb;
            end
            StImmWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StTrap: trap = 1'b1;
            // Unused encodings 14/15 fall into the sticky trap.
            default: state_d = StTrap;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StRst;
        else        state_q <= state_d;
    end

    // Memory-wait counter: counts stalled cycles, restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 wait_cnt_q <= 8'd0;
        else if (state_d != state_q) wait_cnt_q <= 8'd0;
        else if (wait_inc)          wait_cnt_q <= wait_cnt_q + 8'd1;
    end

    assign bus.pc_en      = pc_write | (branch & bus.zero);
    assign bus.ir_write   = ir_write;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.iord       = iord;
    assign bus.reg_write  = reg_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.pc_src     = pc_src;
    assign bus.ext_zero   = ext_zero;
    assign bus.retire     = retire;
    assign bus.trap       = trap;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: reference model of the instruction flow checked
// every negative edge, plus directed literal checks on key cycles.
module tb_multicycle_ctrl;
    localparam int TO = 15;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       ext_zero;
        logic       retire;
        logic       trap;
        logic [3:0] state;
    } outs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   ret_cnt = 0;
    logic chk_en = 1'b0;
    int   m_state;
    int   m_wait;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Instruction flow as a sequence of phases; m_wait = cycles spent in current phase.
    function automatic int model_next(int st, logic [5:0] op, logic rdy, int waits);
        case (st)
            0: return 1;
            1: return rdy ? 2 : ((waits == TO) ? 13 : 1);
            2: begin
                if (op == 6'h00) return 7;
                if (op == 6'h23 || op == 6'h2B) return 3;
                if (op == 6'h04) return 9;
                if (op == 6'h02) return 10;
                if (op == 6'h08 || op == 6'h0C || op == 6'h0D) return 11;
                return 13;
            end
            3: return (op == 6'h23) ? 4 : 6;
            4: return rdy ? 5 : ((waits == TO) ? 13 : 4);
            6: return rdy ? 1 : ((waits == TO) ? 13 : 6);
            7: return 8;
            11: return 12;
            13: return 13;
            5, 8, 9, 10, 12: return 1;
            default: return 13;
        endcase
    endfunction

    function automatic outs_t model_out(int st, logic [5:0] op, logic z, logic rdy);
        outs_t o;
        o = '0;
        o.state = st[3:0];
        case (st)
            1:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_en = rdy; end
            2:  o.alu_src_b = 2'b11;
            3:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            4:  begin o.mem_read = 1; o.iord = 1; end
            5:  begin o.reg_write = 1; o.mem_to_reg = 1; o.retire = 1; end
            6:  begin o.mem_write = 1; o.iord = 1; o.retire = rdy; end
            7:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            8:  begin o.reg_write = 1; o.reg_dst = 1; o.retire = 1; end
            9:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.retire = 1;
                      o.pc_en = z; end
            10: begin o.pc_en = 1; o.pc_src = 2'b10; o.retire = 1; end
            11: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 2'b11;
                      o.ext_zero = (op == 6'h0C || op == 6'h0D); end
            12: begin o.reg_write = 1; o.retire = 1; end
            13: o.trap = 1;
            default: ;
        endcase
        return o;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_wait  <= 1;
        end else begin
            m_state <= model_next(m_state, bus.opcode, bus.mem_ready, m_wait);
            m_wait  <= (model_next(m_state, bus.opcode, bus.mem_ready, m_wait) != m_state) ?
                       1 : m_wait + 1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        outs_t act, exp;
        if (chk_en) begin
            act = {bus.pc_en, bus.ir_write, bus.mem_read, bus.mem_write, bus.iord,
                   bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                   bus.alu_op, bus.pc_src, bus.ext_zero, bus.retire, bus.trap, bus.state};
            exp = model_out(m_state, bus.opcode, bus.zero, bus.mem_ready);
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL cycle_outputs t=%0t model_state=%0d got=%h want=%h",
                         $time, m_state, act, exp);
            end
            if (bus.retire) ret_cnt++;
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input logic [5:0] op, input logic rdy, input logic z);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        bus.zero      = z;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r0;
        bus.opcode = 6'h00; bus.mem_ready = 1'b0; bus.zero = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        lit("reset_state", int'(bus.state), 0);
        lit("reset_no_strobe", int'(bus.mem_read | bus.mem_write), 0);
        cyc(6'h00, 1'b0, 1'b0);
        lit("first_edge_fetch", int'(bus.state), 1);

        // R-type: 1,2,7,8,1 with a single retire
        r0 = ret_cnt;
        cyc(6'h00, 1'b1, 1'b0); lit("rtype_decode", int'(bus.state), 2);
        cyc(6'h00, 1'b0, 1'b0); lit("rtype_exec", int'(bus.state), 7);
        cyc(6'h00, 1'b0, 1'b0); lit("rtype_aluwb", int'(bus.state), 8);
        lit("rtype_wb_ctrl", int'({bus.reg_write, bus.reg_dst}), 3);
        cyc(6'h00, 1'b0, 1'b0); lit("rtype_back_fetch", int'(bus.state), 1);
        lit("rtype_retire_once", ret_cnt - r0, 1);

        // lw with three stalled MEM_RD cycles: retire lands on cycle 8
        cyc(6'h23, 1'b1, 1'b0);
        cyc(6'h23, 1'b0, 1'b0);
        cyc(6'h23, 1'b0, 1'b0); lit("lw_memrd", int'(bus.state), 4);
        for (int i = 0; i < 3; i++) cyc(6'h23, 1'b0, 1'b0);
        lit("lw_still_memrd", int'(bus.state), 4);
        cyc(6'h23, 1'b1, 1'b0); lit("lw_memwb_cycle8", int'(bus.state), 5);
        lit("lw_mem_to_reg", int'({bus.mem_to_reg, bus.retire}), 3);
        cyc(6'h23, 1'b0, 1'b0);

        // beq taken then not taken
        cyc(6'h04, 1'b1, 1'b1); cyc(6'h04, 1'b0, 1'b1);
        lit("beq_taken", int'({bus.pc_en, bus.pc_src}), 5);
        cyc(6'h04, 1'b0, 1'b0);
        cyc(6'h04, 1'b1, 1'b0); cyc(6'h04, 1'b0, 1'b0);
        lit("beq_not_taken", int'({bus.pc_en, bus.pc_src}), 1);
        cyc(6'h04, 1'b0, 1'b0);

        // ori zero-extends, addi sign-extends
        cyc(6'h0D, 1'b1, 1'b0); cyc(6'h0D, 1'b0, 1'b0);
        lit("ori_imm", int'({bus.ext_zero, bus.alu_op}), 7);
        cyc(6'h0D, 1'b0, 1'b0); cyc(6'h0D, 1'b0, 1'b0);
        cyc(6'h08, 1'b1, 1'b0); cyc(6'h08, 1'b0, 1'b0);
        lit("addi_imm", int'({bus.ext_zero, bus.alu_op}), 3);
        cyc(6'h08, 1'b0, 1'b0); cyc(6'h08, 1'b0, 1'b0);

        // jump
        cyc(6'h02, 1'b1, 1'b0);
        cyc(6'h02, 1'b0, 1'b0);
        lit("jump_pc", int'({bus.pc_en, bus.pc_src}), 6);
        cyc(6'h02, 1'b0, 1'b0);

        // sw: retire only combinationally with mem_ready
        cyc(6'h2B, 1'b1, 1'b0); cyc(6'h2B, 1'b0, 1'b0); cyc(6'h2B, 1'b0, 1'b0);
        cyc(6'h2B, 1'b0, 1'b0);
        lit("sw_wait_no_retire", int'({bus.state, bus.retire}), 12);
        bus.mem_ready = 1'b1; #1;
        lit("sw_ready_retire", int'(bus.retire), 1);
        cyc(6'h2B, 1'b1, 1'b0); lit("sw_done", int'(bus.state), 1);

        // ready on the last permitted FETCH cycle beats the timeout
        for (int i = 0; i < TO - 1; i++) cyc(6'h00, 1'b0, 1'b0);
        cyc(6'h00, 1'b1, 1'b0); lit("ready_beats_timeout", int'(bus.state), 2);
        cyc(6'h00, 1'b0, 1'b0); cyc(6'h00, 1'b0, 1'b0); cyc(6'h00, 1'b0, 1'b0);

        // timeout: trap after exactly 15 FETCH cycles, sticky
        for (int i = 0; i < TO - 1; i++) cyc(6'h00, 1'b0, 1'b0);
        lit("fetch_14_cycles", int'(bus.state), 1);
        cyc(6'h00, 1'b0, 1'b0); lit("fetch_timeout_trap", int'(bus.state), 13);
        for (int i = 0; i < 4; i++) cyc(6'h00, 1'b1, 1'b0);
        lit("trap_sticky", int'(bus.trap), 1);
        rst_n = 1'b0; #1;
        lit("trap_clears_in_reset", int'({bus.trap, bus.state}), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        cyc(6'h00, 1'b0, 1'b0);

        // illegal opcode traps from DECODE
        cyc(6'h3F, 1'b1, 1'b0); cyc(6'h3F, 1'b0, 1'b0);
        lit("illegal_op_trap", int'(bus.trap), 1);
        rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
        cyc(6'h00, 1'b0, 1'b0);

        // asynchronous reset in the middle of a pending store
        cyc(6'h2B, 1'b1, 1'b0); cyc(6'h2B, 1'b0, 1'b0); cyc(6'h2B, 1'b0, 1'b0);
        cyc(6'h2B, 1'b0, 1'b0);
        lit("memwr_pending", int'(bus.mem_write), 1);
        #2 rst_n = 1'b0; #1;
        lit("async_reset_outputs", int'({bus.mem_write, bus.iord, bus.state}), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        cyc(6'h00, 1'b0, 1'b0); lit("fetch_after_release", int'(bus.state), 1);

        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum number of consecutive cycles a memory-wait state waits for mem_ready before trapping (legal range 1..255).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  6  instr[31:26] from the instruction register; stable outside FETCH.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completion handshake for the current read or write.
REQ-007 pc_en  output  1  PC load enable, equal to pc_write OR (branch AND zero).
REQ-008 ir_write, mem_read, mem_write, iord  output  1 each  IR load; memory read/write strobes; address select (0 = PC, 1 = ALUOut).
REQ-009 reg_write, reg_dst, mem_to_reg  output  1 each  register write enable; destination select (1 = rd, 0 = rt); writeback select (1 = MDR).
REQ-010 alu_src_a  output  1  (0 = PC, 1 = rs); alu_src_b  output  2  (00 = rt, 01 = const 4, 10 = extended imm, 11 = extended imm << 2).
REQ-011 alu_op  output  2  (00 add, 01 sub, 10 decode funct, 11 decode opcode); pc_src  output  2  (00 ALU result, 01 ALUOut, 10 jump target).
REQ-012 ext_zero  output  1  immediate extender mode (0 = sign-extend, 1 = zero-extend).
REQ-013 retire  output  1  one-cycle pulse on the final cycle of each instruction; trap  output  1  high while in TRAP.
REQ-014 state  output  4  current state encoding, for debug.

Function
REQ-015 State encoding is RST=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC=7, ALU_WB=8, BRANCH=9, JUMP=10, IMM_EXEC=11, IMM_WB=12, TRAP=13; codes 14-15 go to TRAP.
REQ-016 All outputs are decoded from the state register; mem_ready and zero qualify outputs combinationally only where this section says so. Every output not listed for a state is 0.
REQ-017 RST: all outputs 0; next state FETCH.
REQ-018 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
- ir_write and pc_write are 1 only in the cycle mem_ready=1.
- That cycle moves the FSM to DECODE; otherwise the FSM stays in FETCH.
REQ-019 DECODE: alu_src_a=0, alu_src_b=11, ext_zero=0.
- Next state by opcode: 0x00 -> EXEC; 0x23, 0x2B -> MEM_ADDR; 0x04 -> BRANCH; 0x02 -> JUMP; 0x08, 0x0C, 0x0D -> IMM_EXEC.
- Any other opcode -> TRAP.
REQ-020 MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_zero=0; next state MEM_RD if opcode=0x23, otherwise MEM_WR.
REQ-021 MEM_RD: mem_read=1, iord=1; advances to MEM_WB on mem_ready=1. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1; next state FETCH.
REQ-022 MEM_WR: mem_write=1, iord=1; retire=1 and next state FETCH in the cycle mem_ready=1.
REQ-023 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next state ALU_WB. ALU_WB: reg_write=1, reg_dst=1, retire=1; next state FETCH.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1 (internal), retire=1; next state FETCH. pc_en follows zero in the same cycle.
REQ-025 JUMP: pc_write=1, pc_src=10, retire=1; next state FETCH.
REQ-026 IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11, ext_zero=1 if opcode is 0x0C or 0x0D, else 0; next state IMM_WB. IMM_WB: reg_write=1, reg_dst=0, retire=1; next state FETCH.
REQ-027 Wait counter (8-bit):
- Increments on each cycle in FETCH, MEM_RD or MEM_WR with mem_ready=0.
- Clears on every state change.
- If mem_ready=0 when the count equals TIMEOUT-1, the next state is TRAP.
- mem_ready=1 in that same cycle takes priority over the timeout.
REQ-028 TRAP: trap=1, all other outputs 0; sticky until rst_n is asserted.

Reset
REQ-029 rst_n low forces state=RST and wait counter=0 immediately (asynchronously), so all outputs are 0 at any point mid-instruction, including during a pending memory handshake.
REQ-030 After rst_n deasserts, the first rising edge enters FETCH; no memory strobe is asserted before that edge.

Verification
REQ-031 R-type (opcode 0x00), mem_ready=1 in FETCH -> states 1,2,7,8,1; reg_write and reg_dst =1 in ALU_WB; retire pulses once.
REQ-032 lw (0x23), mem_ready held 0 for 3 cycles in MEM_RD -> 3 extra MEM_RD cycles, then MEM_WB with mem_to_reg=1; total 8 cycles from FETCH to retire.
REQ-033 beq (0x04): zero=1 -> pc_en=1, pc_src=01 in BRANCH; repeated with zero=0 -> pc_en=0.
REQ-034 ori (0x0D) -> ext_zero=1 and alu_op=11 in IMM_EXEC; addi (0x08) -> ext_zero=0.
REQ-035 mem_ready held 0 in FETCH with TIMEOUT=15 -> TRAP after exactly 15 FETCH cycles; opcode 0x3F -> TRAP from DECODE; trap stays 1 until rst_n is low.
REQ-036 rst_n pulsed low mid-MEM_WR -> all outputs 0 immediately (no clock edge needed); state=1 one cycle after release.
